// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arb
//  Purpose  : Arbiter and burst sequencer for the single external memory port.
//             Owners: MMU page-table walker (1-beat PTE read), ICACHE refill
//             (line read), DCACHE refill/writeback (line read or write).
//             One owner at a time; 128-bit beats are split from / merged into
//             512-bit lines; one response pulse per transaction.
//  Revision : 1.0 - initial release
//
//  Optional feature macro: MEM_ARB_TIMEOUT_EN
//    defined   -> watchdog counter plus o_mem_arb_err output
//    undefined -> no watchdog, FSM waits indefinitely on the bus
//
//  Ports
//    clk, rst                 clock, synchronous active-high reset
//    i_flush                  cancels / suppresses PTW traffic only
//    i_ptw_req/paddr          PTE read request;  o_ptw_ack/o_ptw_rdat response
//    i_ic_req/paddr           ICACHE refill;     o_ic_vld/o_ic_dat response
//    i_dc_req/we/paddr/wdat/wmask  DCACHE line op; o_dc_done/o_dc_rdat response
//    o_mem_ext_*              burst command and write beat to the bus
//    i_ext_mmu_rdy            command accepted
//    i_ext_mmu_rd_ack/rdat    read beat valid / data
//    i_ext_mmu_wr_ack         write beat consumed
//    o_mem_arb_err            (MEM_ARB_TIMEOUT_EN only) watchdog response flag
//    o_mem_arb_busy           FSM not idle
// ============================================================================
module mem_port_arb #(
   parameter int PHY_ADDR_WIDTH = 34,
   parameter int LINE_BEATS     = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_flush,
   input  logic                        i_ptw_req,
   input  logic [PHY_ADDR_WIDTH-1:0]   i_ptw_paddr,
   output logic                        o_ptw_ack,
   output logic [31:0]                 o_ptw_rdat,
   input  logic                        i_ic_req,
   input  logic [PHY_ADDR_WIDTH-1:0]   i_ic_paddr,
   output logic                        o_ic_vld,
   output logic [128*LINE_BEATS-1:0]   o_ic_dat,
   input  logic                        i_dc_req,
   input  logic                        i_dc_we,
   input  logic [PHY_ADDR_WIDTH-1:0]   i_dc_paddr,
   input  logic [128*LINE_BEATS-1:0]   i_dc_wdat,
   input  logic [16*LINE_BEATS-1:0]    i_dc_wmask,
   output logic                        o_dc_done,
   output logic [128*LINE_BEATS-1:0]   o_dc_rdat,
   output logic                        o_mem_ext_rden,
   output logic                        o_mem_ext_wren,
   output logic [PHY_ADDR_WIDTH-1:0]   o_mem_ext_paddr,
   output logic [2:0]                  o_mem_ext_burst,
   output logic [15:0]                 o_mem_ext_mask,
   output logic [127:0]                o_mem_ext_wdat,
   output logic                        o_mem_ext_burst_start,
   output logic                        o_mem_ext_burst_end,
   input  logic                        i_ext_mmu_rdy,
   input  logic                        i_ext_mmu_rd_ack,
   input  logic [127:0]                i_ext_mmu_rdat,
   input  logic                        i_ext_mmu_wr_ack,
`ifdef MEM_ARB_TIMEOUT_EN
   output logic                        o_mem_arb_err,
`endif
   output logic                        o_mem_arb_busy
);

   localparam int LINE_W = 128 * LINE_BEATS;
   localparam int MASK_W = 16 * LINE_BEATS;
   localparam int CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_PTW = 2'd0,
      OWN_IC  = 2'd1,
      OWN_DC  = 2'd2
   } owner_t;

   state_t                    state;
   owner_t                    owner;
   logic [PHY_ADDR_WIDTH-1:0] paddr;
   logic                      we;
   logic [LINE_W-1:0]         wdat;
   logic [MASK_W-1:0]         wmask;
   logic [127:0]              beat [LINE_BEATS];
   logic [CNT_W-1:0]          beat_cnt;
   logic                      rr_r;          // 1 = DCACHE wins a cache tie
   logic                      ptw_flushed;   // flush seen while a PTW burst drains

   logic                      last_beat;
   logic                      beat_ack;
   logic                      ptw_live;
   logic [LINE_W-1:0]         line_in;
   logic [31:0]               pte_word;

   assign last_beat = (owner == OWN_PTW) ? (beat_cnt == '0)
                                         : (beat_cnt == CNT_W'(LINE_BEATS - 1));
   // rd_ack is meaningless during a write burst and vice versa
   assign beat_ack  = (state == DATA) && (we ? i_ext_mmu_wr_ack : i_ext_mmu_rd_ack);
   assign ptw_live  = !ptw_flushed && !i_flush;
   // PTW bursts are a single beat, so beat0 is the incoming read data
   assign pte_word  = i_ext_mmu_rdat[{paddr[3:2], 5'd0} +: 32];

   // Full line as it will look once the current (last) beat is captured
   always_comb begin
      line_in = '0;
      for (int k = 0; k < LINE_BEATS; k++) begin
         line_in[128*k +: 128] = (beat_cnt == CNT_W'(k)) ? i_ext_mmu_rdat : beat[k];
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            err_q;
   logic            progress;
   logic            ptw_abort;
   logic            wd_fire;

   assign progress  = ((state == CMD) && i_ext_mmu_rdy) || beat_ack;
   assign ptw_abort = (state == CMD) && (owner == OWN_PTW) && i_flush;
   assign wd_fire   = ((state == CMD) || (state == DATA)) && !progress && !ptw_abort
                      && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign o_mem_arb_err = (state == RESP) && err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= OWN_PTW;
         paddr       <= '0;
         we          <= 1'b0;
         wdat        <= '0;
         wmask       <= '0;
         beat_cnt    <= '0;
         rr_r        <= 1'b1;
         ptw_flushed <= 1'b0;
         o_ptw_rdat  <= '0;
         o_ic_dat    <= '0;
         o_dc_rdat   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         wd_cnt      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               if (i_ptw_req && !i_flush) begin
                  owner       <= OWN_PTW;
                  paddr       <= i_ptw_paddr;
                  we          <= 1'b0;
                  ptw_flushed <= 1'b0;
                  state       <= CMD;
               end else if (i_ic_req && (!i_dc_req || !rr_r)) begin
                  owner <= OWN_IC;
                  paddr <= {i_ic_paddr[PHY_ADDR_WIDTH-1:6], 6'd0};
                  we    <= 1'b0;
                  rr_r  <= 1'b1;   // DCACHE gets the next tie
                  state <= CMD;
               end else if (i_dc_req) begin
                  owner <= OWN_DC;
                  paddr <= {i_dc_paddr[PHY_ADDR_WIDTH-1:6], 6'd0};
                  we    <= i_dc_we;
                  wdat  <= i_dc_wdat;
                  wmask <= i_dc_wmask;
                  rr_r  <= 1'b0;   // ICACHE gets the next tie
                  state <= CMD;
               end
            end

            CMD: begin
               if ((owner == OWN_PTW) && i_flush) begin
                  state <= IDLE;   // nothing accepted yet worth keeping
               end else if (i_ext_mmu_rdy) begin
                  state    <= DATA;
                  beat_cnt <= '0;
               end
            end

            DATA: begin
               if ((owner == OWN_PTW) && i_flush) begin
                  ptw_flushed <= 1'b1;
               end
               if (beat_ack) begin
                  if (!we) begin
                     beat[beat_cnt] <= i_ext_mmu_rdat;
                  end
                  if (last_beat) begin
                     state <= RESP;
                     if (!we) begin
                        case (owner)
                           OWN_PTW: if (ptw_live) o_ptw_rdat <= pte_word;
                           OWN_IC:  o_ic_dat  <= line_in;
                           default: o_dc_rdat <= line_in;
                        endcase
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end

            RESP: begin
               state       <= IDLE;
               beat_cnt    <= '0;
               ptw_flushed <= 1'b0;
            end

            default: state <= IDLE;
         endcase

`ifdef MEM_ARB_TIMEOUT_EN
         if (((state == CMD) || (state == DATA)) && !progress) begin
            wd_cnt <= wd_cnt + 1'b1;
         end else begin
            wd_cnt <= '0;
         end
         if (state == RESP) begin
            err_q <= 1'b0;
         end
         if (wd_fire) begin
            state  <= RESP;
            err_q  <= 1'b1;
            wd_cnt <= '0;
            case (owner)
               OWN_PTW: if (ptw_live) o_ptw_rdat <= '0;
               OWN_IC:  o_ic_dat  <= '0;
               default: o_dc_rdat <= '0;
            endcase
         end
`endif
      end
   end

   // Bus-side and response outputs decode the registered state only,
   // except the PTW ack which a flush in the response cycle still kills.
   always_comb begin
      o_mem_ext_rden        = (state == CMD) && !we;
      o_mem_ext_wren        = ((state == CMD) || (state == DATA)) && we;
      o_mem_ext_burst_start = (state == CMD);
      o_mem_ext_burst_end   = (state == DATA) && last_beat;
      o_mem_ext_paddr       = '0;
      o_mem_ext_burst       = 3'd0;
      o_mem_ext_wdat        = '0;
      o_mem_ext_mask        = '0;
      if (state == CMD) begin
         o_mem_ext_paddr = paddr;
         o_mem_ext_burst = (owner == OWN_PTW) ? 3'd1 : 3'(LINE_BEATS);
      end
      if (((state == CMD) || (state == DATA)) && we) begin
         o_mem_ext_wdat = wdat[128*beat_cnt +: 128];
         o_mem_ext_mask = wmask[16*beat_cnt +: 16];
      end
      o_ptw_ack      = (state == RESP) && (owner == OWN_PTW) && ptw_live;
      o_ic_vld       = (state == RESP) && (owner == OWN_IC);
      o_dc_done      = (state == RESP) && (owner == OWN_DC);
      o_mem_arb_busy = (state != IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arb
//  Purpose  : Self-checking bench for mem_port_arb. Expected responses are
//             queued when a request is issued; a monitor pops and compares
//             each response pulse. Bus-side behaviour is checked inline by
//             the bus responder task.
//  Revision : 1.0 - initial release
//  Macro    : MEM_ARB_TIMEOUT_EN adds the watchdog scenario
// ============================================================================
module tb_mem_port_arb;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_flush;
   logic          i_ptw_req;
   logic [33:0]   i_ptw_paddr;
   logic          o_ptw_ack;
   logic [31:0]   o_ptw_rdat;
   logic          i_ic_req;
   logic [33:0]   i_ic_paddr;
   logic          o_ic_vld;
   logic [511:0]  o_ic_dat;
   logic          i_dc_req;
   logic          i_dc_we;
   logic [33:0]   i_dc_paddr;
   logic [511:0]  i_dc_wdat;
   logic [63:0]   i_dc_wmask;
   logic          o_dc_done;
   logic [511:0]  o_dc_rdat;
   logic          o_mem_ext_rden;
   logic          o_mem_ext_wren;
   logic [33:0]   o_mem_ext_paddr;
   logic [2:0]    o_mem_ext_burst;
   logic [15:0]   o_mem_ext_mask;
   logic [127:0]  o_mem_ext_wdat;
   logic          o_mem_ext_burst_start;
   logic          o_mem_ext_burst_end;
   logic          i_ext_mmu_rdy;
   logic          i_ext_mmu_rd_ack;
   logic [127:0]  i_ext_mmu_rdat;
   logic          i_ext_mmu_wr_ack;
   logic          o_mem_arb_busy;
`ifdef MEM_ARB_TIMEOUT_EN
   logic          o_mem_arb_err;
`endif

   mem_port_arb #(
      .PHY_ADDR_WIDTH (34),
      .LINE_BEATS     (4),
`ifdef MEM_ARB_TIMEOUT_EN
      .TIMEOUT_CYCLES (15)
`else
      .TIMEOUT_CYCLES (1023)
`endif
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .i_flush               (i_flush),
      .i_ptw_req             (i_ptw_req),
      .i_ptw_paddr           (i_ptw_paddr),
      .o_ptw_ack             (o_ptw_ack),
      .o_ptw_rdat            (o_ptw_rdat),
      .i_ic_req              (i_ic_req),
      .i_ic_paddr            (i_ic_paddr),
      .o_ic_vld              (o_ic_vld),
      .o_ic_dat              (o_ic_dat),
      .i_dc_req              (i_dc_req),
      .i_dc_we               (i_dc_we),
      .i_dc_paddr            (i_dc_paddr),
      .i_dc_wdat             (i_dc_wdat),
      .i_dc_wmask            (i_dc_wmask),
      .o_dc_done             (o_dc_done),
      .o_dc_rdat             (o_dc_rdat),
      .o_mem_ext_rden        (o_mem_ext_rden),
      .o_mem_ext_wren        (o_mem_ext_wren),
      .o_mem_ext_paddr       (o_mem_ext_paddr),
      .o_mem_ext_burst       (o_mem_ext_burst),
      .o_mem_ext_mask        (o_mem_ext_mask),
      .o_mem_ext_wdat        (o_mem_ext_wdat),
      .o_mem_ext_burst_start (o_mem_ext_burst_start),
      .o_mem_ext_burst_end   (o_mem_ext_burst_end),
      .i_ext_mmu_rdy         (i_ext_mmu_rdy),
      .i_ext_mmu_rd_ack      (i_ext_mmu_rd_ack),
      .i_ext_mmu_rdat        (i_ext_mmu_rdat),
      .i_ext_mmu_wr_ack      (i_ext_mmu_wr_ack),
`ifdef MEM_ARB_TIMEOUT_EN
      .o_mem_arb_err         (o_mem_arb_err),
`endif
      .o_mem_arb_busy        (o_mem_arb_busy)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      int           kind;   // 0 = PTW, 1 = ICACHE, 2 = DCACHE
      logic [511:0] data;
      bit           chk;    // compare response data
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   resp_cyc = 0;
   int   cmd_cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input int kind, input logic [511:0] data, input bit chk);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.chk  = chk;
      exp_q.push_back(e);
   endtask

   int           mon_kind;
   logic [511:0] mon_got;
   exp_t         mon_e;

   always @(negedge clk) begin
      if (!rst && (o_ptw_ack || o_ic_vld || o_dc_done)) begin
         mon_kind = o_ptw_ack ? 0 : (o_ic_vld ? 1 : 2);
         mon_got  = o_ptw_ack ? {480'd0, o_ptw_rdat} : (o_ic_vld ? o_ic_dat : o_dc_rdat);
         resp_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: owner %0d responded, none expected", mon_kind);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_owner", mon_kind, mon_e.kind);
            if (mon_e.chk) check("resp_data", mon_got, mon_e.data);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plays the external bus for one burst: waits for the command, accepts it
   // after rdy_delay cycles, then acks every beat with gap idle cycles before it.
   task automatic serve_burst(input int nbeats, input int rdy_delay, input int gap,
                              input logic [511:0] line, input logic [33:0] exp_paddr,
                              input logic [63:0] wmask, input bit exp_we);
      int n;
      n = 0;
      while (!o_mem_ext_burst_start && n < 40) begin
         tick();
         n++;
      end
      if (!o_mem_ext_burst_start) begin
         checks++;
         failures++;
         $display("FAIL cmd_wait: burst_start 0 after 40 cycles, required 1");
         return;
      end
      cmd_cyc = cyc;
      check("cmd_paddr", o_mem_ext_paddr, exp_paddr);
      check("cmd_burst", o_mem_ext_burst, nbeats);
      check("cmd_rden", o_mem_ext_rden, !exp_we);
      check("cmd_wren", o_mem_ext_wren, exp_we);
      repeat (rdy_delay) tick();
      if (rdy_delay > 0) check("cmd_hold", o_mem_ext_burst_start, 1'b1);
      i_ext_mmu_rdy = 1'b1;
      tick();
      i_ext_mmu_rdy = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         repeat (gap) tick();
         check("burst_end", o_mem_ext_burst_end, (k == nbeats - 1));
         if (exp_we) begin
            check("wr_mask", o_mem_ext_mask, wmask[16*k +: 16]);
            check("wr_dat", o_mem_ext_wdat, line[128*k +: 128]);
            i_ext_mmu_wr_ack = 1'b1;
         end else begin
            i_ext_mmu_rd_ack = 1'b1;
            i_ext_mmu_rdat   = line[128*k +: 128];
         end
         tick();
         i_ext_mmu_rd_ack = 1'b0;
         i_ext_mmu_wr_ack = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic [511:0] la, lb, lc, ld, lw, lp;
      int           req_cyc, ptw_rc, t0, n;

      rst = 1'b1;
      i_flush = 1'b0;
      i_ptw_req = 1'b0;  i_ptw_paddr = '0;
      i_ic_req = 1'b0;   i_ic_paddr = '0;
      i_dc_req = 1'b0;   i_dc_we = 1'b0;  i_dc_paddr = '0;
      i_dc_wdat = '0;    i_dc_wmask = '0;
      i_ext_mmu_rdy = 1'b0;  i_ext_mmu_rd_ack = 1'b0;
      i_ext_mmu_rdat = '0;   i_ext_mmu_wr_ack = 1'b0;
      repeat (3) tick();

      // reset state
      check("rst_busy", o_mem_arb_busy, 1'b0);
      check("rst_rden", o_mem_ext_rden, 1'b0);
      check("rst_wren", o_mem_ext_wren, 1'b0);
      check("rst_start", o_mem_ext_burst_start, 1'b0);
      check("rst_ptw_rdat", o_ptw_rdat, 32'h0);
      check("rst_resp", {o_ptw_ack, o_ic_vld, o_dc_done}, 3'b000);
      rst = 1'b0;
      tick();

      // PTW minimum latency read
      lp = {384'd0, 128'h11111111_200000CF_33333333_44444444};
      i_ptw_req   = 1'b1;
      i_ptw_paddr = 34'h0_8000_0008;
      req_cyc     = cyc;
      push(0, {480'd0, 32'h2000_00CF}, 1'b1);
      tick();
      i_ptw_req = 1'b0;
      serve_burst(1, 0, 0, lp, 34'h0_8000_0008, 64'd0, 1'b0);
      tick();
      check("ptw_latency", resp_cyc - req_cyc, 3);
      check("ptw_busy_after", o_mem_arb_busy, 1'b0);

      // Cache ties: DCACHE first after reset, then ICACHE, then DCACHE
      la = {{4{32'hA3A3_A3A3}}, {4{32'hA2A2_A2A2}}, {4{32'hA1A1_A1A1}}, {4{32'hA0A0_A0A0}}};
      lb = {{4{32'hB3B3_B3B3}}, {4{32'hB2B2_B2B2}}, {4{32'hB1B1_B1B1}}, {4{32'hB0B0_B0B0}}};
      lc = {{4{32'hC3C3_C3C3}}, {4{32'hC2C2_C2C2}}, {4{32'hC1C1_C1C1}}, {4{32'hC0C0_C0C0}}};
      i_ic_req   = 1'b1;  i_ic_paddr = 34'h0_0000_107F;
      i_dc_req   = 1'b1;  i_dc_we = 1'b0;  i_dc_paddr = 34'h1_2345_6789;
      push(2, la, 1'b1);
      push(1, lb, 1'b1);
      push(2, lc, 1'b1);
      tick();
      serve_burst(4, 0, 0, la, 34'h1_2345_6780, 64'd0, 1'b0);
      serve_burst(4, 0, 0, lb, 34'h0_0000_1040, 64'd0, 1'b0);
      i_ic_req = 1'b0;
      serve_burst(4, 0, 0, lc, 34'h1_2345_6780, 64'd0, 1'b0);
      i_dc_req = 1'b0;
      tick();

      // PTW beats ICACHE; ICACHE command follows the PTW response
      lp = {384'd0, 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333};
      ld = {{4{32'hD3D3_D3D3}}, {4{32'hD2D2_D2D2}}, {4{32'hD1D1_D1D1}}, {4{32'hD0D0_D0D0}}};
      i_ptw_req = 1'b1;  i_ptw_paddr = 34'h0_0000_2004;
      i_ic_req  = 1'b1;  i_ic_paddr  = 34'h0_0000_4000;
      push(0, {480'd0, 32'hCCCC_2222}, 1'b1);
      push(1, ld, 1'b1);
      tick();
      i_ptw_req = 1'b0;
      serve_burst(1, 0, 0, lp, 34'h0_0000_2004, 64'd0, 1'b0);
      tick();
      ptw_rc = resp_cyc;
      serve_burst(4, 0, 0, ld, 34'h0_0000_4000, 64'd0, 1'b0);
      i_ic_req = 1'b0;
      check("ic_after_ptw", cmd_cyc - ptw_rc, 2);
      tick();

      // DCACHE write: delayed rdy, wr_ack every other cycle
      lw = {{4{32'hE3E3_E3E3}}, {4{32'hE2E2_E2E2}}, {4{32'hE1E1_E1E1}}, {4{32'hE0E0_E0E0}}};
      i_dc_req   = 1'b1;  i_dc_we = 1'b1;  i_dc_paddr = 34'h0_0004_0010;
      i_dc_wdat  = lw;
      i_dc_wmask = 64'hFFFF_0000_FFFF_00FF;
      push(2, '0, 1'b0);
      tick();
      i_dc_req   = 1'b0;  i_dc_we = 1'b0;
      i_dc_wdat  = '0;    i_dc_wmask = '0;
      serve_burst(4, 3, 1, lw, 34'h0_0004_0000, 64'hFFFF_0000_FFFF_00FF, 1'b1);
      check("dc_done_last_ack", o_dc_done, 1'b1);
      tick();

      // Flush during PTW command: abort, no response
      i_ptw_req = 1'b1;  i_ptw_paddr = 34'h0_0000_3000;
      tick();
      i_ptw_req = 1'b0;
      check("flush_cmd_rden_before", o_mem_ext_rden, 1'b1);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      check("flush_cmd_rden_after", o_mem_ext_rden, 1'b0);
      check("flush_cmd_busy", o_mem_arb_busy, 1'b0);
      repeat (3) tick();

      // Flush during PTW data: burst drains, no ack, data held
      i_ptw_req = 1'b1;  i_ptw_paddr = 34'h0_0000_3008;
      tick();
      i_ptw_req = 1'b0;
      i_ext_mmu_rdy = 1'b1;
      tick();
      i_ext_mmu_rdy = 1'b0;
      check("flush_data_end", o_mem_ext_burst_end, 1'b1);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      check("flush_data_busy", o_mem_arb_busy, 1'b1);
      i_ext_mmu_rd_ack = 1'b1;
      i_ext_mmu_rdat   = 128'h5555_5555_6666_6666_7777_7777_8888_8888;
      tick();
      i_ext_mmu_rd_ack = 1'b0;
      check("flush_resp_busy", o_mem_arb_busy, 1'b1);
      check("flush_no_ack", o_ptw_ack, 1'b0);
      check("flush_rdat_held", o_ptw_rdat, 32'hCCCC_2222);
      tick();
      check("flush_idle_busy", o_mem_arb_busy, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
      // Watchdog: rdy never comes
      i_ic_req = 1'b1;  i_ic_paddr = 34'h0_0000_5000;
      push(1, '0, 1'b1);
      tick();
      i_ic_req = 1'b0;
      t0 = cyc;
      n  = 0;
      while (!o_mem_arb_err && n < 40) begin
         tick();
         n++;
      end
      check("to_err", o_mem_arb_err, 1'b1);
      check("to_cycles", cyc - t0, 15);
      check("to_vld", o_ic_vld, 1'b1);
      tick();
      check("to_err_clear", o_mem_arb_err, 1'b0);
`endif

      repeat (3) tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
